// File: rtl/spi_master_engine_if.sv
// spi_master_engine_if: upstream byte stream, status and SPI pins of the SPI master engine
interface spi_master_engine_if;
  logic       tx_valid, tx_ready, tx_last;
  logic [7:0] tx_data, rx_data;
  logic       rx_valid, busy;
  logic       spi_sck, spi_mosi, spi_miso, spi_cs_n;
  modport master (
    input  tx_valid, tx_data, tx_last, spi_miso,
    output tx_ready, rx_valid, rx_data, busy, spi_sck, spi_mosi, spi_cs_n
  );
  modport slave (
    output tx_valid, tx_data, tx_last, spi_miso,
    input  tx_ready, rx_valid, rx_data, busy, spi_sck, spi_mosi, spi_cs_n
  );
endinterface

// File: rtl/spi_master_engine.sv
// spi_master_engine: byte-wide SPI mode-0 master; chip select stays low across bytes until tx_last
module spi_master_engine #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input logic aclk,
  input logic aresetn,
  spi_master_engine_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, TAIL, GAP} state_t;
  state_t     state;
  logic [7:0] cnt, tx_sh, rx_sh, rx_data;
  logic [3:0] edges;
  logic       last, sck, mosi, cs_n, tx_ready, rx_valid, busy, div_done;
  assign div_done     = cnt == 8'(CLK_DIV - 1);
  assign bus.tx_ready = tx_ready;
  assign bus.rx_valid = rx_valid;
  assign bus.rx_data  = rx_data;
  assign bus.busy     = busy;
  assign bus.spi_sck  = sck;
  assign bus.spi_mosi = mosi;
  assign bus.spi_cs_n = cs_n;
  // SHIFT idles one half-period before the first rise so the 8th fall lands at 17*CLK_DIV
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state    <= IDLE;
      cnt      <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      edges    <= '0;
      last     <= 1'b0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      cnt      <= cnt + 8'd1;
      case (state)
        IDLE, HOLD: begin
          tx_ready <= 1'b1;
          cnt      <= '0;
          if (bus.tx_valid && tx_ready) begin
            state    <= SETUP;
            tx_sh    <= bus.tx_data;
            last     <= bus.tx_last;
            mosi     <= bus.tx_data[7];
            cs_n     <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            edges    <= '0;
          end
        end
        SETUP: if (div_done) begin
          state <= SHIFT;
          cnt   <= '0;
        end
        SHIFT: if (div_done) begin
          cnt   <= '0;
          sck   <= ~sck;
          edges <= edges + 4'd1;
          if (!sck) rx_sh <= {rx_sh[6:0], bus.spi_miso};
          else if (edges == 4'd15) begin
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
            tx_ready <= ~last;
            state    <= last ? TAIL : HOLD;
          end else begin
            tx_sh <= {tx_sh[6:0], 1'b0};
            mosi  <= tx_sh[6];
          end
        end
        TAIL: if (div_done) begin
          state <= GAP;
          cnt   <= '0;
          cs_n  <= 1'b1;
          mosi  <= 1'b0;
        end
        GAP: if (cnt == 8'(CS_GAP - 1)) begin
          state    <= IDLE;
          busy     <= 1'b0;
          tx_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_master_engine.sv
// tb_spi_master_engine: randomized bench checking the engine every cycle against a closed-form timing model
module tb_spi_master_engine;
  localparam int D = 4, G = 2;
  logic aclk = 1'b0, aresetn;
  int nvec = 0, nerr = 0;
  spi_master_engine_if bus();
  spi_master_engine #(.CLK_DIV(D), .CS_GAP(G)) dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));
  always #5 aclk = ~aclk;

  bit         started = 0, m_last = 0, prev_sck = 0, prev_cs = 1, prev_rdy = 0;
  int         post = 0, t = 0, nf = 8, hs = 0;
  logic [7:0] m_byte = '0, m_slv = '0, exp_rx = '0, next_slv = '0, fb = '0;
  logic [7:0] fq[$], dq[$];
  int         fpul = 0, frxv = 0, fbit = 0, dpul = 0, drxv = 0, frames = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {tx_ready, busy, cs_n, sck, mosi, rx_valid} as a function of cycles t since the last accept
  function automatic logic [5:0] model(input bit st, input int pst, input int tt, input bit l, input logic [7:0] b);
    int p, k;
    bit cs, sck, mo;
    if (!st) return {pst > 0, 5'b01000};
    p   = tt / D;
    k   = (p < 3) ? 0 : (((p - 1) / 2 > 7) ? 7 : (p - 1) / 2);
    sck = p >= 2 && p <= 16 && p % 2 == 0;
    cs  = l && tt >= 18 * D;
    mo  = cs ? 1'b0 : b[3'(7 - k)];
    return {l ? tt >= 18 * D + G : tt >= 17 * D, !l || tt < 18 * D + G, cs, sck, mo, tt == 17 * D};
  endfunction

  always @(posedge aclk) begin
    logic [5:0] e;
    #1;
    if (!aresetn) begin
      started = 0; post = 0; exp_rx = '0; nf = 8;
      fq.delete(); fpul = 0; frxv = 0; fbit = 0;
    end else begin
      if (bus.tx_valid && prev_rdy) hs++;
      e = model(started, post, t, m_last, m_byte);
      if (bus.tx_valid && e[5]) begin
        started = 1; t = 0; m_byte = bus.tx_data; m_last = bus.tx_last; m_slv = next_slv; nf = 0;
      end else t++;
      post++;
      if (started && t == 17 * D) exp_rx = m_slv;
    end
    e = model(started, post, t, m_last, m_byte);
    chk("tx_ready", bus.tx_ready, e[5]);
    chk("busy", bus.busy, e[4]);
    chk("spi_cs_n", bus.spi_cs_n, e[3]);
    chk("spi_sck", bus.spi_sck, e[2]);
    chk("spi_mosi", bus.spi_mosi, e[1]);
    chk("rx_valid", bus.rx_valid, e[0]);
    chk("rx_data", bus.rx_data, exp_rx);
    if (aresetn) begin
      if (prev_cs && !bus.spi_cs_n) begin fq.delete(); fpul = 0; frxv = 0; fbit = 0; end
      if (!prev_sck && bus.spi_sck) begin
        fpul++;
        fb = {fb[6:0], bus.spi_mosi};
        fbit++;
        if (fbit == 8) begin fq.push_back(fb); fbit = 0; end
      end
      if (bus.rx_valid) frxv++;
      if (!prev_cs && bus.spi_cs_n) begin dq = fq; dpul = fpul; drxv = frxv; frames++; end
      if (prev_sck && !bus.spi_sck) nf++;
    end
    bus.spi_miso = (nf < 8) ? m_slv[3'(7 - nf)] : 1'b0;
    prev_sck = bus.spi_sck;
    prev_cs  = bus.spi_cs_n;
    prev_rdy = bus.tx_ready;
  end

  task automatic send(input logic [7:0] d, input bit l, input logic [7:0] s);
    int n = 0;
    @(negedge aclk);
    bus.tx_valid = 1'b1; bus.tx_data = d; bus.tx_last = l; next_slv = s;
    while (!bus.tx_ready && n < 300) begin @(negedge aclk); n++; end
    chk("accept_wait", bus.tx_ready, 1);
    @(negedge aclk);
    bus.tx_valid = 1'b0; bus.tx_data = 8'($urandom); bus.tx_last = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge aclk);
    while (bus.busy && n < 500) begin @(negedge aclk); n++; end
    chk("idle_wait", bus.busy, 0);
  endtask

  initial begin
    int h0, f0, pul, r, n;
    bit ps;
    logic [7:0] lit;
    bus.tx_valid = 1'b0; bus.tx_data = '0; bus.tx_last = 1'b0;
    aresetn = 1'b1;
    #1 aresetn = 1'b0;
    #2;
    chk("rst_async_cs_n", bus.spi_cs_n, 1);
    chk("rst_async_ready", bus.tx_ready, 0);
    repeat (6) begin
      @(negedge aclk);
      bus.tx_valid = 1'($urandom); bus.tx_data = 8'($urandom); bus.tx_last = 1'($urandom);
    end
    @(negedge aclk);
    bus.tx_valid = 1'b0; aresetn = 1'b1;
    @(posedge aclk); #2 chk("ready_after_release", bus.tx_ready, 1);

    h0 = hs; lit = 8'b0000_0110; pul = 0; ps = 0;
    @(negedge aclk);
    next_slv = 8'hFF; bus.tx_valid = 1'b1; bus.tx_data = 8'h06; bus.tx_last = 1'b1;
    @(posedge aclk); #2;
    bus.tx_valid = 1'b0; bus.tx_data = 8'hFF; bus.tx_last = 1'b0;
    for (int k = 1; k <= 74; k++) begin
      @(posedge aclk); #2;
      if (bus.spi_sck && !ps) begin
        pul++;
        chk($sformatf("lit_rise_time%0d", pul), k, 2 * D * pul);
        chk($sformatf("lit_mosi_bit%0d", pul), bus.spi_mosi, lit[3'(8 - pul)]);
      end
      ps = bus.spi_sck;
      if (k == 67) chk("lit_rxv_early", bus.rx_valid, 0);
      if (k == 68) begin chk("lit_rxv", bus.rx_valid, 1); chk("lit_rx_data", bus.rx_data, 8'hFF); end
      if (k == 71) chk("lit_cs_low", bus.spi_cs_n, 0);
      if (k == 72) chk("lit_cs_high", bus.spi_cs_n, 1);
      if (k == 73) chk("lit_ready_early", bus.tx_ready, 0);
      if (k == 74) chk("lit_ready", bus.tx_ready, 1);
    end
    chk("lit_sck_pulses", pul, 8);
    chk("lit_accepts", hs - h0, 1);

    send(8'h03, 1'b1, 8'hA5);
    wait_idle();
    chk("rx_path_data", bus.rx_data, 8'hA5);
    chk("rx_path_mosi", dq.size() == 1 ? dq[0] : 8'hXX, 8'h03);

    f0 = frames;
    send(8'h02, 1'b0, 8'($urandom));
    send(8'h00, 1'b0, 8'($urandom));
    send(8'hF0, 1'b0, 8'($urandom));
    send(8'hAA, 1'b1, 8'h5C);
    wait_idle();
    chk("frame_count", frames - f0, 1);
    chk("frame_len", dq.size(), 4);
    chk("frame_pulses", dpul, 32);
    chk("frame_rx_valids", drxv, 4);
    if (dq.size() == 4) begin
      chk("eeprom_instr", dq[0], 8'h02);
      chk("eeprom_addr", {dq[1], dq[2]}, 16'h00F0);
      chk("eeprom_data", dq[3], 8'hAA);
    end
    chk("frame_last_rx", bus.rx_data, 8'h5C);

    h0 = hs;
    send(8'h3C, 1'b1, 8'($urandom));
    repeat (17 * D) begin
      @(negedge aclk);
      bus.tx_valid = 1'b1; bus.tx_data = 8'($urandom); bus.tx_last = 1'($urandom);
    end
    @(negedge aclk);
    bus.tx_valid = 1'b0;
    chk("busy_accepts", hs - h0, 1);
    wait_idle();
    chk("busy_mosi", dq.size() == 1 ? dq[0] : 8'hXX, 8'h3C);

    send(8'h81, 1'b0, 8'($urandom));
    r = 0; n = 0; ps = bus.spi_sck;
    while (r < 3 && n < 200) begin
      @(negedge aclk);
      if (bus.spi_sck && !ps) r++;
      ps = bus.spi_sck;
      n++;
    end
    chk("third_rise", r, 3);
    #2 aresetn = 1'b0;
    #1;
    chk("midrst_cs_n", bus.spi_cs_n, 1);
    chk("midrst_sck", bus.spi_sck, 0);
    chk("midrst_mosi", bus.spi_mosi, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_rx_valid", bus.rx_valid, 0);
    chk("midrst_rx_data", bus.rx_data, 0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #2 chk("midrst_ready", bus.tx_ready, 1);
    send(8'h5A, 1'b1, 8'hC3);
    wait_idle();
    chk("post_rst_rx", bus.rx_data, 8'hC3);
    chk("post_rst_mosi", dq.size() == 1 ? dq[0] : 8'hXX, 8'h5A);

    repeat (40) begin
      repeat ($urandom_range(0, 3)) @(negedge aclk);
      send(8'($urandom), $urandom_range(0, 3) == 0, 8'($urandom));
    end
    send(8'($urandom), 1'b1, 8'($urandom));
    wait_idle();
    repeat (4) @(negedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
